// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU one-entry holding registers, round-robin grant, registered broadcast.
// Optional macro CDB_ARB_BR_PRIORITY_EN lets an occupied BR slot win regardless of the round-robin pointer.

package cdb_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        rd_valid;
        logic [5:0]  rd_paddr;
        logic [31:0] rd_data;
        logic [5:0]  rob_addr;
    } cdb_t;

endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NUM_FU-1:0]      fu_valid,
    input  cdb_t [NUM_FU-1:0]      fu_pkt,
    output logic [NUM_FU-1:0]      fu_ready,
    output cdb_t                   cdb,
    output logic [1:0]             cdb_src
);

    localparam int IW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int BR_IDX = 2;

    logic [NUM_FU-1:0] hold_v;
    cdb_t              hold_pkt [NUM_FU];
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     rr_next;
    logic              found;
    logic              br_pri;
    logic              grant_any;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] xfer;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_FU) begin
            sum = sum - NUM_FU;
        end
        return IW'(sum);
    endfunction

    // First occupied slot at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        br_pri = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!found && hold_v[rr_index(rr_ptr, k)]) begin
                found  = 1'b1;
                winner = rr_index(rr_ptr, k);
            end
        end
`ifdef CDB_ARB_BR_PRIORITY_EN
        if (hold_v[BR_IDX]) begin
            found  = 1'b1;
            winner = IW'(BR_IDX);
            br_pri = 1'b1;
        end
`endif
    end

    always_comb begin
        grant_any = found & ~flush & ~rst;
        grant     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            grant[i] = grant_any && (winner == IW'(i));
        end
        // A granted slot empties at the edge, so it can be refilled in the same cycle.
        fu_ready = ~{NUM_FU{rst | flush}} & (~hold_v | grant);
        xfer     = fu_valid & fu_ready;
        rr_next  = (winner == IW'(NUM_FU - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v  <= '0;
            rr_ptr  <= '0;
            cdb     <= '0;
            cdb_src <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (xfer[i]) begin
                    hold_v[i] <= 1'b1;
                end else if (grant[i] || flush) begin
                    hold_v[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                cdb       <= hold_pkt[winner];
                cdb.valid <= 1'b1;
                cdb_src   <= 2'(winner);
                if (!br_pri) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                cdb.valid <= 1'b0;
            end
        end
    end

    // Packet storage needs no reset; hold_v qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (xfer[i]) begin
                hold_pkt[i] <= fu_pkt[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed per-cycle vector table plus hand-written arbitration sequences.
// The BR-priority sequence follows CDB_ARB_BR_PRIORITY_EN; the round-robin table runs only without it.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [3:0]       fu_valid;
    cdb_t [3:0]       fu_pkt;
    logic [3:0]       fu_ready;
    cdb_t             cdb;
    logic [1:0]       cdb_src;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        logic       rst;
        logic       flush;
        logic [3:0] valid;
        logic [7:0] tag;
        logic [3:0] exp_ready;
        logic       exp_v;
        logic [1:0] exp_src;
        logic [7:0] exp_tag;
    } vec_t;

    vec_t vecs [$];

    cdb_arbiter #(.NUM_FU(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_pkt   (fu_pkt),
        .fu_ready (fu_ready),
        .cdb      (cdb),
        .cdb_src  (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Packet each FU would present for a given tag; tag 01 on ARITH is the fixed single-result packet.
    function automatic cdb_t make_pkt(input int i, input logic [7:0] tag);
        cdb_t p;
        p.valid    = 1'b1;
        p.rd_valid = 1'b1;
        p.rob_addr = 6'(tag[5:0] + 6'(i));
        if (tag == 8'h01 && i == 0) begin
            p.rd_paddr = 6'd5;
            p.rd_data  = 32'hDEADBEEF;
        end else begin
            p.rd_paddr = 6'(tag[5:0] ^ 6'(i));
            p.rd_data  = {tag, 8'(i), 16'hC0DE};
        end
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [7:0] tag);
        rst      = r;
        flush    = f;
        fu_valid = v;
        for (int i = 0; i < 4; i++) begin
            fu_pkt[i] = make_pkt(i, tag);
        end
    endtask

    task automatic check_bcast(input string name, input logic [1:0] src, input logic [7:0] tag);
        cdb_t e;
        e = make_pkt(int'(src), tag);
        check_value({name, " cdb_valid"}, 32'(cdb.valid), 32'd1);
        check_value({name, " cdb_src"}, 32'(cdb_src), 32'(src));
        check_value({name, " rd_data"}, cdb.rd_data, e.rd_data);
        check_value({name, " rd_paddr"}, 32'(cdb.rd_paddr), 32'(e.rd_paddr));
        check_value({name, " rob_addr"}, 32'(cdb.rob_addr), 32'(e.rob_addr));
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.rst, v.flush, v.valid, v.tag);
    endtask

    task automatic checkOutput(input int r, input vec_t v);
        string n;
        n = $sformatf("row%0d", r);
        check_value({n, " fu_ready"}, 32'(fu_ready), 32'(v.exp_ready));
        if (v.exp_v) begin
            check_bcast(n, v.exp_src, v.exp_tag);
        end else begin
            check_value({n, " cdb_valid"}, 32'(cdb.valid), 32'd0);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic [3:0] v, input logic [7:0] tag,
                       input logic [3:0] rdy, input logic ev, input logic [1:0] es, input logic [7:0] et);
        vec_t x;
        x = '{r, f, v, tag, rdy, ev, es, et};
        vecs.push_back(x);
    endtask

    task automatic fill_table;
        // single result: visible in cycle 3 only
        add(0, 0, 4'b0001, 8'h01, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd0, 8'h01);
        // MUL_DIV grant brings rr_ptr back to 0
        add(0, 0, 4'b1000, 8'h02, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        // all four contend
        add(0, 0, 4'b1111, 8'h03, 4'b1111, 1, 2'd3, 8'h02);
        add(0, 0, 4'b0000, 8'h00, 4'b0001, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b0011, 1, 2'd0, 8'h03);
        add(0, 0, 4'b0000, 8'h00, 4'b0111, 1, 2'd1, 8'h03);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd2, 8'h03);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd3, 8'h03);
        // back-to-back ARITH with reload on grant
        add(0, 0, 4'b0001, 8'h10, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0001, 8'h11, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0001, 8'h12, 4'b1111, 1, 2'd0, 8'h10);
        add(0, 0, 4'b0001, 8'h13, 4'b1111, 1, 2'd0, 8'h11);
        add(0, 0, 4'b0001, 8'h14, 4'b1111, 1, 2'd0, 8'h12);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd0, 8'h13);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd0, 8'h14);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        // flush drops held MEM and MUL_DIV
        add(0, 0, 4'b1010, 8'h20, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 1, 4'b0000, 8'h00, 4'b0000, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        // BR grant moves rr_ptr to 3, then wrap 3 -> 0
        add(0, 0, 4'b0100, 8'h30, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b1001, 8'h31, 4'b1111, 1, 2'd2, 8'h30);
        add(0, 0, 4'b0000, 8'h00, 4'b1110, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd3, 8'h31);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd0, 8'h31);
        // reset mid-stream discards held BR packet and zeroes rr_ptr
        add(0, 0, 4'b0110, 8'h40, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1011, 0, 2'd0, 8'h00);
        add(1, 0, 4'b1000, 8'h41, 4'b0000, 1, 2'd1, 8'h40);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b1010, 8'h42, 4'b1111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b0111, 0, 2'd0, 8'h00);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd1, 8'h42);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 1, 2'd3, 8'h42);
        add(0, 0, 4'b0000, 8'h00, 4'b1111, 0, 2'd0, 8'h00);
    endtask

    // Expects rr_ptr = 0 and all slots empty on entry.
    task automatic br_sequence;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [3:0] rdy2;
        logic [1:0] s1;
        logic [1:0] order [3];
        int         n;
`ifdef CDB_ARB_BR_PRIORITY_EN
        m1 = 4'b0001; s1 = 2'd0; m2 = 4'b1110; rdy2 = 4'b0101; n = 3;
        order = '{2'd2, 2'd1, 2'd3};
`else
        m1 = 4'b0100; s1 = 2'd2; m2 = 4'b1100; rdy2 = 4'b1011; n = 2;
        order = '{2'd3, 2'd2, 2'd0};
`endif
        drive(0, 0, m1, 8'h50);
        #1;
        check_value("br load1 fu_ready", 32'(fu_ready), 32'hF);
        tick;
        drive(0, 0, 4'b0000, 8'h00);
        #1;
        check_value("br wait1 cdb_valid", 32'(cdb.valid), 32'd0);
        tick;
        #1;
        check_bcast("br first", s1, 8'h50);
        tick;
        drive(0, 0, m2, 8'h51);
        #1;
        check_value("br load2 cdb_valid", 32'(cdb.valid), 32'd0);
        tick;
        drive(0, 0, 4'b0000, 8'h00);
        #1;
        check_value("br arb fu_ready", 32'(fu_ready), 32'(rdy2));
        tick;
        for (int k = 0; k < n; k++) begin
            #1;
            check_bcast($sformatf("br order%0d", k), order[k], 8'h51);
            tick;
        end
        #1;
        check_value("br drained cdb_valid", 32'(cdb.valid), 32'd0);
    endtask

    initial begin
        drive(1, 0, 4'b0000, 8'h00);
        tick;
        tick;
        #1;
        check_value("reset cdb_valid", 32'(cdb.valid), 32'd0);
        check_value("reset rd_data", cdb.rd_data, 32'd0);
        check_value("reset rd_paddr", 32'(cdb.rd_paddr), 32'd0);
        check_value("reset cdb_src", 32'(cdb_src), 32'd0);
        check_value("reset fu_ready", 32'(fu_ready), 32'd0);
        tick;
`ifndef CDB_ARB_BR_PRIORITY_EN
        fill_table();
        $display("[TB] applying %0d vectors", vecs.size());
        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r]);
            #1;
            checkOutput(r, vecs[r]);
            tick;
        end
`else
        drive(0, 0, 4'b0000, 8'h00);
        tick;
`endif
        br_sequence();
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, 4, number of functional-unit requesters. Index 0 = ARITH, 1 = MEM, 2 = BR, 3 = MUL_DIV.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset; synchronous and active-high.
REQ-004 Port flush, input, 1, branch-mispredict flush from the ROB.
REQ-005 Port fu_valid, input, NUM_FU, per-FU result valid.
REQ-006 Port fu_pkt, input, NUM_FU x cdb_t, per-FU result packet (rd_paddr, rd_data, rd_valid, rob_addr, ...).
REQ-007 Port fu_ready, output, NUM_FU, per-FU accept.
REQ-008 Port cdb, output, cdb_t, registered broadcast bus; cdb.valid marks a live broadcast.
REQ-009 Port cdb_src, output, 2, index of the FU that sourced the current cdb; valid only when cdb.valid = 1.

Function
REQ-010 Each FU SHALL own a one-entry holding register: hold_v[i] plus hold_pkt[i].
REQ-011 Handshake: fu_ready[i] = !flush & (!hold_v[i] | grant[i]). A transfer occurs when fu_valid[i] & fu_ready[i].
REQ-012 A transfer SHALL load hold_pkt[i] and set hold_v[i] at the next edge.
REQ-013 Grant and reload of the same slot in one cycle SHALL be supported without a bubble.
REQ-014 Arbitration is combinational over hold_v. It grants at most one slot per cycle, round-robin, searching from rr_ptr upward modulo NUM_FU.
REQ-015 On a grant, the next edge SHALL register cdb <= hold_pkt[winner] with cdb.valid = 1 and cdb_src = winner. It SHALL also clear hold_v[winner] unless reloaded, and set rr_ptr <= (winner + 1) mod NUM_FU, wrapping 3 -> 0.
REQ-016 With no grant, the next edge SHALL set cdb.valid = 0 and leave rr_ptr unchanged. Other cdb fields are don't-care.
REQ-017 Latency: a result transferred in cycle N SHALL appear on cdb no earlier than cycle N+2. With no contention it SHALL appear exactly at N+2.
REQ-018 Throughput SHALL be one broadcast per cycle while any hold_v is set.
REQ-019 Fairness: an occupied slot SHALL be granted within NUM_FU cycles.
REQ-020 All slots full: the held FUs see fu_ready = 0 until their slot is granted, and no packet is dropped.
REQ-021 Flush: the next edge SHALL clear every hold_v and set cdb.valid = 0. rr_ptr is unchanged. No grant is issued and no transfer is accepted in the flush cycle.
REQ-022 cdb_src SHALL be the 2-bit binary encoding of the winner index.

Reset
REQ-023 While rst = 1 at an edge, the block SHALL clear all hold_v and set rr_ptr = 0.
REQ-024 While rst = 1 at an edge, the block SHALL set cdb.valid = 0, all other cdb fields = 0, and cdb_src = 0.
REQ-025 During rst = 1, fu_ready SHALL read 0.
REQ-026 rst SHALL take priority over flush and over any transfer or grant in the same cycle.
REQ-027 Reset asserted mid-operation SHALL discard held packets.

Configuration
REQ-028 Macro CDB_ARB_BR_PRIORITY_EN.
REQ-029 When CDB_ARB_BR_PRIORITY_EN is defined, an occupied BR slot (index 2) SHALL win regardless of rr_ptr, and rr_ptr SHALL be left unchanged on a BR-priority grant.
REQ-030 When CDB_ARB_BR_PRIORITY_EN is undefined, BR participates in plain round-robin per REQ-014.

Verification
REQ-031 Single result: fu_valid = 0001 with rd_paddr = 5, rd_data = 0xDEADBEEF in cycle 1 -> cdb.valid = 1, rd_paddr = 5, rd_data = 0xDEADBEEF, cdb_src = 0 in cycle 3 only.
REQ-032 Contention: all four FUs valid in one cycle with rr_ptr = 0 -> cdb_src = 0, 1, 2, 3 on four consecutive cycles; fu_ready[3] = 0 until its slot is granted.
REQ-033 Back-to-back: ARITH holds fu_valid = 1 for 5 cycles with distinct rd_data -> 5 consecutive cdb broadcasts in order with no bubble and fu_ready[0] = 1 throughout.
REQ-034 Flush: MEM and MUL_DIV held, flush = 1 for one cycle -> cdb.valid = 0 on the next two cycles; both packets never broadcast.
REQ-035 Wrap and reset: rr_ptr = 3 after grants, then MUL_DIV and ARITH both valid -> MUL_DIV granted first, then ARITH. rst mid-stream -> cdb.valid = 0, rr_ptr = 0 next cycle.
REQ-036 CDB_ARB_BR_PRIORITY_EN defined: rr_ptr = 3, BR and MUL_DIV held -> BR granted first, MUL_DIV second.
